// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer
// Sequences scalar or LANES-wide vector loads/stores onto a single-port,
// one-word-per-cycle data memory and stalls the pipeline while doing so.
//
// Build option: define VMS_STRIDE_EN to add the stride port. Without it the
// elements are consecutive words (stride fixed at 1).
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle request strobe (accepted only when idle)
//   isStore         1 = store, 0 = load
//   isVector        1 = LANES elements, 0 = one element
//   baseAddr        word address of element 0
//   stride          word distance between elements (VMS_STRIDE_EN only)
//   storeData       store operands, lane i at [32i+31:32i]
//   memReadData     combinational read data from memory
//   memAddress      word address to memory (0 outside an access)
//   memWriteEnable  write strobe (memory commits on the falling edge)
//   memWriteData    write data (0 outside an access)
//   busy            stall request, high while accessing and in the done cycle
//   done            one-cycle completion pulse
//   loadData        assembled load result, same lane layout as storeData
module vector_mem_sequencer #(
    parameter int unsigned LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  isStore,
    input  logic                  isVector,
    input  logic [31:0]           baseAddr,
`ifdef VMS_STRIDE_EN
    input  logic [31:0]           stride,
`endif
    input  logic [LANES*32-1:0]   storeData,
    input  logic [31:0]           memReadData,
    output logic [31:0]           memAddress,
    output logic                  memWriteEnable,
    output logic [31:0]           memWriteData,
    output logic                  busy,
    output logic                  done,
    output logic [LANES*32-1:0]   loadData
);

    localparam int unsigned DATA_W = LANES * 32;
    localparam int unsigned IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state;
    logic                store_q;
    logic [31:0]         stride_q;
    logic [DATA_W-1:0]   store_data_q;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    last_idx;
    logic [31:0]         eff_stride;
    logic [DATA_W-1:0]   store_shift;

`ifdef VMS_STRIDE_EN
    assign eff_stride = stride;
`else
    assign eff_stride = 32'd1;
`endif

    // Remaining store lanes move down so the next element is always lane 0.
    assign store_shift = DATA_W'(store_data_q >> 32);

    // Sequencer: memory-side outputs are registered one edge ahead so they are
    // stable for the whole access cycle they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            store_q        <= 1'b0;
            stride_q       <= 32'd0;
            store_data_q   <= '0;
            idx            <= '0;
            last_idx       <= '0;
            memAddress     <= 32'd0;
            memWriteEnable <= 1'b0;
            memWriteData   <= 32'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            loadData       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state          <= ACCESS;
                        busy           <= 1'b1;
                        store_q        <= isStore;
                        stride_q       <= eff_stride;
                        store_data_q   <= storeData;
                        idx            <= '0;
                        last_idx       <= isVector ? IDX_W'(LANES - 1) : '0;
                        memAddress     <= baseAddr;
                        memWriteEnable <= isStore;
                        memWriteData   <= isStore ? storeData[31:0] : 32'd0;
                        if (!isStore) begin
                            loadData <= '0;
                        end
                    end
                end

                ACCESS: begin
                    if (!store_q) begin
                        for (int unsigned i = 0; i < LANES; i++) begin
                            if (idx == IDX_W'(i)) begin
                                loadData[32*i +: 32] <= memReadData;
                            end
                        end
                    end
                    if (idx == last_idx) begin
                        state          <= DONE;
                        done           <= 1'b1;
                        memAddress     <= 32'd0;
                        memWriteEnable <= 1'b0;
                        memWriteData   <= 32'd0;
                    end else begin
                        idx          <= IDX_W'(idx + IDX_W'(1));
                        // Running sum equals base + idx*stride modulo 2^32.
                        memAddress   <= memAddress + stride_q;
                        store_data_q <= store_shift;
                        memWriteData <= store_q ? store_shift[31:0] : 32'd0;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer with a 256-word memory model
// (address bits [7:0]), read combinationally and written on the falling edge.
module tb_vector_mem_sequencer;

    localparam int unsigned LANES = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               isStore;
    logic               isVector;
    logic [31:0]        baseAddr;
`ifdef VMS_STRIDE_EN
    logic [31:0]        stride;
`endif
    logic [LANES*32-1:0] storeData;
    logic [31:0]        memReadData;
    logic [31:0]        memAddress;
    logic               memWriteEnable;
    logic [31:0]        memWriteData;
    logic               busy;
    logic               done;
    logic [LANES*32-1:0] loadData;

    logic [31:0] mem [256] = '{default: 32'd0};
    int n_writes = 0;
    int n_done   = 0;

    int n_checks = 0;
    int n_fail   = 0;

    vector_mem_sequencer #(.LANES(LANES)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .isStore        (isStore),
        .isVector       (isVector),
        .baseAddr       (baseAddr),
`ifdef VMS_STRIDE_EN
        .stride         (stride),
`endif
        .storeData      (storeData),
        .memReadData    (memReadData),
        .memAddress     (memAddress),
        .memWriteEnable (memWriteEnable),
        .memWriteData   (memWriteData),
        .busy           (busy),
        .done           (done),
        .loadData       (loadData)
    );

    initial forever #5 clk = ~clk;

    assign memReadData = mem[memAddress[7:0]];

    always @(negedge clk) begin
        if (memWriteEnable) begin
            mem[memAddress[7:0]] <= memWriteData;
            n_writes <= n_writes + 1;
        end
        if (done) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; returns in access cycle 1.
    task automatic issue(input logic st, input logic vec, input logic [31:0] base,
                         input logic [127:0] data);
        start     = 1'b1;
        isStore   = st;
        isVector  = vec;
        baseAddr  = base;
        storeData = data;
        tick();
        start     = 1'b0;
        storeData = '0;
    endtask

    localparam logic [31:0] A = 32'hAAAA_0001;
    localparam logic [31:0] B = 32'hBBBB_0002;
    localparam logic [31:0] C = 32'hCCCC_0003;
    localparam logic [31:0] D = 32'hDDDD_0004;
    localparam logic [31:0] E = 32'hEEEE_0005;

    initial begin
        logic [127:0] sd;
        logic [127:0] sd2;
        logic [127:0] sd3;
        logic [31:0]  exp_addr [4];
        logic [31:0]  lane;
        int           w0;
        int           d0;

        sd  = {D, C, B, A};
        sd2 = {32'h2222_0004, 32'h2222_0003, 32'h2222_0002, 32'h2222_0001};
        sd3 = {32'h3333_0004, 32'h3333_0003, 32'h3333_0002, 32'h3333_0001};

        rst = 1'b1; start = 1'b0; isStore = 1'b0; isVector = 1'b0;
        baseAddr = '0; storeData = '0;
`ifdef VMS_STRIDE_EN
        stride = 32'd1;
`endif
        #2;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_we",   128'(memWriteEnable), 128'(0));
        chk("rst_addr", 128'(memAddress), 128'(0));
        chk("rst_wd",   128'(memWriteData), 128'(0));
        chk("rst_load", loadData, 128'(0));
        tick();
        rst = 1'b0;
        tick();

        // Vector store with a spurious start during cycle 2.
        w0 = n_writes;
        issue(1'b1, 1'b1, 32'h10, sd);
        for (int i = 0; i < 4; i++) begin
            lane = sd[32*i +: 32];
            chk("vst_we",   128'(memWriteEnable), 128'(1));
            chk("vst_addr", 128'(memAddress), 128'(32'h10 + 32'(i)));
            chk("vst_wd",   128'(memWriteData), 128'(lane));
            chk("vst_busy", 128'(busy), 128'(1));
            chk("vst_done", 128'(done), 128'(0));
            if (i == 1) begin
                start = 1'b1; isStore = 1'b0; baseAddr = 32'h80; storeData = '1;
            end
            tick();
            start = 1'b0;
        end
        chk("vst_c5_done", 128'(done), 128'(1));
        chk("vst_c5_busy", 128'(busy), 128'(1));
        chk("vst_c5_we",   128'(memWriteEnable), 128'(0));
        chk("vst_c5_addr", 128'(memAddress), 128'(0));
        chk("vst_c5_wd",   128'(memWriteData), 128'(0));
        tick();
        chk("vst_c6_done", 128'(done), 128'(0));
        chk("vst_c6_busy", 128'(busy), 128'(0));
        chk("vst_m10", 128'(mem[8'h10]), 128'(A));
        chk("vst_m11", 128'(mem[8'h11]), 128'(B));
        chk("vst_m12", 128'(mem[8'h12]), 128'(C));
        chk("vst_m13", 128'(mem[8'h13]), 128'(D));
        chk("vst_m80", 128'(mem[8'h80]), 128'(0));
        chk("vst_nwr", 128'(n_writes - w0), 128'(4));
        chk("vst_load_untouched", loadData, 128'(0));

        // Vector load of the same words.
        issue(1'b0, 1'b1, 32'h10, '0);
        for (int i = 0; i < 4; i++) begin
            chk("vld_we",   128'(memWriteEnable), 128'(0));
            chk("vld_addr", 128'(memAddress), 128'(32'h10 + 32'(i)));
            chk("vld_busy", 128'(busy), 128'(1));
            tick();
        end
        chk("vld_c5_done", 128'(done), 128'(1));
        chk("vld_c5_busy", 128'(busy), 128'(1));
        chk("vld_data",    loadData, {D, C, B, A});
        tick();
        chk("vld_c6_busy", 128'(busy), 128'(0));
        chk("vld_c6_done", 128'(done), 128'(0));

        // Scalar store must not disturb loadData.
        w0 = n_writes;
        issue(1'b1, 1'b0, 32'h20, {96'd0, E});
        chk("sst_addr", 128'(memAddress), 128'(32'h20));
        chk("sst_wd",   128'(memWriteData), 128'(E));
        chk("sst_we",   128'(memWriteEnable), 128'(1));
        tick();
        chk("sst_done", 128'(done), 128'(1));
        tick();
        chk("sst_m20",  128'(mem[8'h20]), 128'(E));
        chk("sst_nwr",  128'(n_writes - w0), 128'(1));
        chk("sst_hold", loadData, {D, C, B, A});

        // Scalar load clears the vector and fills lane 0 only.
        issue(1'b0, 1'b0, 32'h12, '0);
        chk("sld_clear", loadData, 128'(0));
        chk("sld_addr",  128'(memAddress), 128'(32'h12));
        tick();
        chk("sld_done",  128'(done), 128'(1));
        chk("sld_data",  loadData, {96'd0, C});
        tick();
        chk("sld_idle",  128'(busy), 128'(0));

        // Address wrap across 2^32.
`ifdef VMS_STRIDE_EN
        stride = 32'd4;
        exp_addr = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        issue(1'b1, 1'b1, 32'hFFFF_FFFC, sd2);
`else
        exp_addr = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        issue(1'b1, 1'b1, 32'hFFFF_FFFE, sd2);
`endif
        for (int i = 0; i < 4; i++) begin
            chk("wrap_addr", 128'(memAddress), 128'(exp_addr[i]));
            tick();
        end
        chk("wrap_done", 128'(done), 128'(1));
        tick();
        for (int i = 0; i < 4; i++) begin
            lane = sd2[32*i +: 32];
            chk("wrap_mem", 128'(mem[exp_addr[i][7:0]]), 128'(lane));
        end

        // Reset asserted early in cycle 2 of a vector store.
        w0 = n_writes;
        d0 = n_done;
        issue(1'b1, 1'b1, 32'h30, sd3);
        chk("rmid_c1_addr", 128'(memAddress), 128'(32'h30));
        tick();
        rst = 1'b1;
        #1;
        chk("rmid_busy", 128'(busy), 128'(0));
        chk("rmid_we",   128'(memWriteEnable), 128'(0));
        chk("rmid_addr", 128'(memAddress), 128'(0));
        chk("rmid_wd",   128'(memWriteData), 128'(0));
        chk("rmid_load", loadData, 128'(0));
        tick();
        rst = 1'b0;
        tick(); tick(); tick(); tick();
        chk("rmid_m30",  128'(mem[8'h30]), 128'(sd3[31:0]));
        chk("rmid_m31",  128'(mem[8'h31]), 128'(0));
        chk("rmid_nwr",  128'(n_writes - w0), 128'(1));
        chk("rmid_ndone", 128'(n_done - d0), 128'(0));
        chk("rmid_idle", 128'(busy), 128'(0));

        // First request after reset behaves normally.
        issue(1'b0, 1'b0, 32'h30, '0);
        chk("post_addr", 128'(memAddress), 128'(32'h30));
        tick();
        chk("post_done", 128'(done), 128'(1));
        chk("post_data", loadData, {96'd0, sd3[31:0]});
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
